// File: rtl/seq_detect_sequencer_if.sv
// Handshake bundle between word source/consumer and seq_detect_sequencer.
// Signals: in_valid/in_word/keep_history/in_ready, det_step/det_w/det_z,
// busy, done_valid/done_count/done_ack, and abort when SEQ_SCHED_ABORT_EN.
interface seq_detect_sequencer_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              keep_history;
    logic              in_ready;
    logic              det_step;
    logic              det_w;
    logic              det_z;
    logic              busy;
    logic              done_valid;
    logic [CNT_W-1:0]  done_count;
    logic              done_ack;
`ifdef SEQ_SCHED_ABORT_EN
    logic              abort;
`endif

    modport master (
`ifdef SEQ_SCHED_ABORT_EN
        output abort,
`endif
        output in_valid,
        output in_word,
        output keep_history,
        output done_ack,
        input  in_ready,
        input  det_step,
        input  det_w,
        input  det_z,
        input  busy,
        input  done_valid,
        input  done_count
    );

    modport slave (
`ifdef SEQ_SCHED_ABORT_EN
        input  abort,
`endif
        input  in_valid,
        input  in_word,
        input  keep_history,
        input  done_ack,
        output in_ready,
        output det_step,
        output det_w,
        output det_z,
        output busy,
        output done_valid,
        output done_count
    );
endinterface

// File: rtl/seq_detect_sequencer.sv
// Serialises words MSB first into a run-of-RUN_LEN detector, counts matches
// per word and returns the count on a valid/ack handshake.
// Ports: clock, resetn (sync, active-low), bus (seq_detect_sequencer_if.slave).
// Optional: define SEQ_SCHED_ABORT_EN to add bus.abort (cancel SHIFT/REPORT).
module seq_detect_sequencer #(
    parameter int WORD_W  = 8,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic clock,
    input  logic resetn,
    seq_detect_sequencer_if.slave bus
);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_REPORT
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_word;
    logic [IW-1:0]     r_idx;
    logic [RW-1:0]     r_run;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic              r_hist;
    logic              r_det_z;
    logic              r_done_valid;
    logic [CNT_W-1:0]  r_done_count;

    logic              w_bit;
    logic              w_same;
    logic [RW-1:0]     w_run_nx;
    logic              w_match;
    logic [CNT_W-1:0]  w_cnt_nx;

    assign w_bit  = r_word[r_idx];
    assign w_same = r_hist && (w_bit == r_last);

    // Run length saturates at RUN_LEN so overlapping matches keep firing.
    always_comb begin
        w_run_nx = RW'(1);
        if (w_same) begin
            if (r_run == RW'(RUN_LEN))
                w_run_nx = r_run;
            else
                w_run_nx = r_run + 1'b1;
        end
    end

    assign w_match = (w_run_nx == RW'(RUN_LEN));

    always_comb begin
        w_cnt_nx = r_cnt;
        if (w_match && (r_cnt != {CNT_W{1'b1}}))
            w_cnt_nx = r_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_idx        <= '0;
            r_run        <= '0;
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_hist       <= 1'b0;
            r_det_z      <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_count <= '0;
        end else begin
`ifdef SEQ_SCHED_ABORT_EN
            if (bus.abort && (r_state != S_IDLE)) begin
                r_state      <= S_IDLE;
                r_done_valid <= 1'b0;
                r_det_z      <= 1'b0;
                r_run        <= '0;
                r_hist       <= 1'b0;
            end else
`endif
            begin
                unique case (r_state)
                    S_IDLE: begin
                        r_det_z <= 1'b0;
                        if (bus.in_valid) begin
                            r_word  <= bus.in_word;
                            r_idx   <= IW'(WORD_W - 1);
                            r_cnt   <= '0;
                            if (!bus.keep_history) begin
                                r_run  <= '0;
                                r_hist <= 1'b0;
                            end
                            r_state <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        r_run   <= w_run_nx;
                        r_last  <= w_bit;
                        r_hist  <= 1'b1;
                        r_det_z <= w_match;
                        r_cnt   <= w_cnt_nx;
                        r_idx   <= r_idx - 1'b1;
                        // Last bit: report includes its own match.
                        if (r_idx == '0) begin
                            r_state      <= S_REPORT;
                            r_done_valid <= 1'b1;
                            r_done_count <= w_cnt_nx;
                        end
                    end
                    S_REPORT: begin
                        r_det_z <= 1'b0;
                        if (bus.done_ack) begin
                            r_done_valid <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready   = resetn && (r_state == S_IDLE);
    assign bus.det_step   = (r_state == S_SHIFT);
    assign bus.det_w      = w_bit;
    assign bus.det_z      = r_det_z;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done_valid = r_done_valid;
    assign bus.done_count = r_done_count;
endmodule

// File: tb/tb_seq_detect_sequencer.sv
// Directed bench for seq_detect_sequencer.
// Two DUTs: CNT_W=4 and CNT_W=2.
module tb_seq_detect_sequencer;
  localparam int WW = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  seq_detect_sequencer_if #(.WORD_W(WW), .CNT_W(4)) b1 ();
  seq_detect_sequencer_if #(.WORD_W(WW), .CNT_W(2)) b2 ();

  seq_detect_sequencer #(
    .WORD_W(WW), .RUN_LEN(4), .CNT_W(4)
  ) u1 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (b1)
  );

  seq_detect_sequencer #(
    .WORD_W(WW), .RUN_LEN(4), .CNT_W(2)
  ) u2 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (b2)
  );

  logic          sel;
  logic          tv_valid;
  logic          tv_keep;
  logic          tv_ack;
  logic          tv_abort;
  logic [WW-1:0] tv_word;

  assign b1.in_valid     = tv_valid & ~sel;
  assign b2.in_valid     = tv_valid & sel;
  assign b1.in_word      = tv_word;
  assign b2.in_word      = tv_word;
  assign b1.keep_history = tv_keep;
  assign b2.keep_history = tv_keep;
  assign b1.done_ack     = tv_ack & ~sel;
  assign b2.done_ack     = tv_ack & sel;
`ifdef SEQ_SCHED_ABORT_EN
  assign b1.abort        = tv_abort & ~sel;
  assign b2.abort        = tv_abort & sel;
`endif

  wire w_ready = sel ? b2.in_ready : b1.in_ready;
  wire w_busy  = sel ? b2.busy : b1.busy;
  wire w_z     = sel ? b2.det_z : b1.det_z;
  wire w_step  = sel ? b2.det_step : b1.det_step;
  wire w_dv    = sel ? b2.done_valid
                     : b1.done_valid;
  wire [3:0] w_cnt = sel ? {2'b00, b2.done_count}
                         : b1.done_count;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  task automatic chk(input string tag,
                     input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic run_word(
    input logic s, input logic [WW-1:0] w,
    input logic k, input int exp_cnt,
    input int exp_z, input int hold,
    input string tag);
    int zc;
    int exp_v;
    sel = s;
    @(negedge clock);
    for (int i = 0; i < 20 && !w_ready; i++)
      @(negedge clock);
    chk({tag, "_ready"}, w_ready === 1'b1);
    tv_word  = w;
    tv_keep  = k;
    tv_valid = 1'b1;
    exp_q.push_back(exp_cnt);
    @(posedge clock);
    #1 tv_valid = 1'b0;
    chk({tag, "_busy"}, w_busy === 1'b1);
    chk({tag, "_step"}, w_step === 1'b1);
    zc = 0;
    for (int i = 1; i <= WW; i++) begin
      @(posedge clock);
      #1;
      if (w_z) zc++;
      if (i < WW)
        chk({tag, "_early_dv"}, w_dv === 1'b0);
    end
    chk({tag, "_dv"}, w_dv === 1'b1);
    chk({tag, "_step_off"}, w_step === 1'b0);
    exp_v = exp_q.pop_front();
    chk({tag, "_count"}, int'(w_cnt) == exp_v);
    chk({tag, "_zcount"}, zc == exp_z);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      chk({tag, "_hold_dv"}, w_dv === 1'b1);
      chk({tag, "_hold_cnt"}, int'(w_cnt) == exp_v);
      chk({tag, "_hold_busy"}, w_busy === 1'b1);
      chk({tag, "_hold_rdy"}, w_ready === 1'b0);
    end
    @(negedge clock);
    tv_ack = 1'b1;
    @(posedge clock);
    #1 tv_ack = 1'b0;
    chk({tag, "_dv_drop"}, w_dv === 1'b0);
    chk({tag, "_rdy_back"}, w_ready === 1'b1);
    chk({tag, "_z_off"}, w_z === 1'b0);
  endtask

  initial begin
    resetn   = 1'b0;
    sel      = 1'b0;
    tv_valid = 1'b0;
    tv_keep  = 1'b0;
    tv_ack   = 1'b0;
    tv_abort = 1'b0;
    tv_word  = '0;

    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_ready", w_ready === 1'b0);
    chk("rst_busy", w_busy === 1'b0);
    chk("rst_dv", w_dv === 1'b0);
    chk("rst_z", w_z === 1'b0);
    chk("rst_cnt", w_cnt === 4'd0);
    resetn = 1'b1;
    #1;
    chk("post_rst_ready", w_ready === 1'b1);

    run_word(1'b0, 8'h00, 1'b0, 5, 5, 0, "w00");
    run_word(1'b0, 8'hF0, 1'b0, 2, 2, 0, "wF0");
    run_word(1'b0, 8'hAA, 1'b0, 0, 0, 0, "wAA");
    run_word(1'b0, 8'h03, 1'b0, 3, 3, 0, "w03");
    run_word(1'b0, 8'hC0, 1'b1, 4, 4, 0,
             "wC0_keep");
    run_word(1'b0, 8'hC0, 1'b0, 3, 3, 0,
             "wC0_nokeep");

    run_word(1'b1, 8'h00, 1'b0, 3, 5, 10, "sat");

    sel = 1'b0;
    @(negedge clock);
    tv_word  = 8'h00;
    tv_keep  = 1'b0;
    tv_valid = 1'b1;
    @(posedge clock);
    #1 tv_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 resetn = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_ready_low", w_ready === 1'b0);
    resetn = 1'b1;
    #1;
    chk("midrst_busy", w_busy === 1'b0);
    chk("midrst_dv", w_dv === 1'b0);
    chk("midrst_z", w_z === 1'b0);
    chk("midrst_ready", w_ready === 1'b1);
    run_word(1'b0, 8'h0F, 1'b1, 2, 2, 0,
             "w0F_after_rst");

`ifdef SEQ_SCHED_ABORT_EN
    begin
      int dv_seen;
      sel = 1'b0;
      @(negedge clock);
      tv_word  = 8'h00;
      tv_keep  = 1'b0;
      tv_valid = 1'b1;
      @(posedge clock);
      #1 tv_valid = 1'b0;
      repeat (4) @(posedge clock);
      #1 tv_abort = 1'b1;
      @(posedge clock);
      #1 tv_abort = 1'b0;
      chk("abort_busy", w_busy === 1'b0);
      chk("abort_dv", w_dv === 1'b0);
      chk("abort_z", w_z === 1'b0);
      dv_seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clock);
        #1;
        if (w_dv) dv_seen++;
      end
      chk("abort_no_report", dv_seen == 0);
      run_word(1'b0, 8'hFF, 1'b0, 5, 5, 0,
               "wFF_after_abort");
    end
`endif

    chk("queue_empty", exp_q.size() == 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end
endmodule
